// File: rtl/apvm_delay_pkg.sv
// -----------------------------------------------------------------------------
// apvm_delay_pkg
// Shared types and helpers for the round-robin delay scheduler.
//   sched_state_t : scheduler FSM states (IDLE, COUNT, DONE)
//   DEF_NREQ      : default number of requesters
//   DEF_DW        : default delay-count width
//   rr_next()     : modulo-n increment used to advance the round-robin pointer
// -----------------------------------------------------------------------------
package apvm_delay_pkg;

    localparam int DEF_NREQ = 4;
    localparam int DEF_DW   = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } sched_state_t;

    // (idx + 1) mod n without a divider; idx is always < n.
    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        return (idx + 32'd1 >= n) ? 32'd0 : idx + 32'd1;
    endfunction

endpackage

// File: rtl/apvm_delay_sched_arb.sv
// -----------------------------------------------------------------------------
// apvm_rr_arb
// Combinational round-robin arbiter. The winner is the first set request at
// index ptr, ptr+1, ... (mod NREQ). The pointer register lives in the caller.
// Ports:
//   req        in  NREQ  request vector
//   ptr        in  IW    highest-priority index
//   win_onehot out NREQ  one-hot winner (all zero when nothing requests)
//   win_idx    out IW    winner index (0 when nothing requests)
//   win_valid  out 1     at least one request present
// -----------------------------------------------------------------------------
module apvm_rr_arb
    import apvm_delay_pkg::*;
#(
    parameter int NREQ = DEF_NREQ
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] ptr,
    output logic [NREQ-1:0]         win_onehot,
    output logic [$clog2(NREQ)-1:0] win_idx,
    output logic                    win_valid
);

    localparam int IW = $clog2(NREQ);

    // Scan from the farthest offset back to ptr so the nearest request
    // (lowest offset) is the last assignment and therefore wins.
    always_comb begin
        logic [IW:0] slot;
        win_idx   = '0;
        win_valid = 1'b0;
        slot      = '0;
        for (int ofs = NREQ - 1; ofs >= 0; ofs--) begin
            slot = {1'b0, ptr} + (IW+1)'(ofs);
            if (slot >= (IW+1)'(NREQ)) begin
                slot = slot - (IW+1)'(NREQ);
            end
            if (req[slot[IW-1:0]]) begin
                win_idx   = slot[IW-1:0];
                win_valid = 1'b1;
            end
        end
    end

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_onehot
        assign win_onehot[gi] = win_valid && (win_idx == IW'(gi));
    end

endmodule

// File: rtl/apvm_delay_sched.sv
// -----------------------------------------------------------------------------
// apvm_delay_sched
// Shares one programmable delay down-counter among NREQ requesters using
// round-robin arbitration. A winner's delay is latched at grant, counted down
// to zero, then a one-cycle done pulse is returned to that winner.
// Optional feature macro: APVM_DELAY_SCHED_ABORT_EN (adds abort/aborted).
// Ports:
//   clk      in  1        rising-edge clock
//   rst_n    in  1        asynchronous active-low reset
//   req      in  NREQ     per-requester level request
//   delay_in in  NREQ*DW  packed delays, slice i = delay_in[i*DW +: DW]
//   gnt      out NREQ     one-hot grant while counting
//   done     out NREQ     one-hot one-cycle completion pulse
//   busy     out 1        high in COUNT or DONE
//   cur_id   out IW       active / last-serviced requester
//   dly_val  out DW       latched delay of the active request
//   dly_en   out 1        high while counting
//   abort    in  NREQ     per-requester cancel          (macro only)
//   aborted  out 1        done was caused by an abort   (macro only)
// -----------------------------------------------------------------------------
module apvm_delay_sched
    import apvm_delay_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int DW   = DEF_DW
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*DW-1:0]      delay_in,
    output logic [NREQ-1:0]         gnt,
    output logic [NREQ-1:0]         done,
    output logic                    busy,
    output logic [$clog2(NREQ)-1:0] cur_id,
    output logic [DW-1:0]           dly_val,
    output logic                    dly_en
`ifdef APVM_DELAY_SCHED_ABORT_EN
    ,
    input  logic [NREQ-1:0]         abort,
    output logic                    aborted
`endif
);

    localparam int IW = $clog2(NREQ);

    sched_state_t    state_reg, state_next;
    logic [DW-1:0]   cnt_reg, cnt_next;
    logic [DW-1:0]   dly_val_reg, dly_val_next;
    logic [IW-1:0]   cur_id_reg, cur_id_next;
    logic [IW-1:0]   ptr_reg, ptr_next;
    logic [NREQ-1:0] mask_reg, mask_next;   // one-hot of the active requester

    logic [NREQ-1:0] arb_onehot;
    logic [IW-1:0]   arb_idx;
    logic            arb_valid;
    logic [DW-1:0]   delay_arr [NREQ];

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_delay_unpack
        assign delay_arr[gi] = delay_in[gi*DW +: DW];
    end

    apvm_rr_arb #(.NREQ(NREQ)) u_arb (
        .req        (req),
        .ptr        (ptr_reg),
        .win_onehot (arb_onehot),
        .win_idx    (arb_idx),
        .win_valid  (arb_valid)
    );

`ifdef APVM_DELAY_SCHED_ABORT_EN
    logic abort_hit;
    logic aborted_reg;
    assign abort_hit = abort[cur_id_reg];

    // An abort in COUNT always moves to DONE, so this flag is high for
    // exactly that DONE cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aborted_reg <= 1'b0;
        end else begin
            aborted_reg <= (state_reg == COUNT) && abort_hit;
        end
    end
    assign aborted = aborted_reg;
`else
    localparam logic abort_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            dly_val_reg <= '0;
            cur_id_reg  <= '0;
            ptr_reg     <= '0;
            mask_reg    <= '0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            dly_val_reg <= dly_val_next;
            cur_id_reg  <= cur_id_next;
            ptr_reg     <= ptr_next;
            mask_reg    <= mask_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        dly_val_next = dly_val_reg;
        cur_id_next  = cur_id_reg;
        ptr_next     = ptr_reg;
        mask_next    = mask_reg;
        case (state_reg)
            IDLE: begin
                if (arb_valid) begin
                    state_next   = COUNT;
                    cnt_next     = delay_arr[arb_idx];
                    dly_val_next = delay_arr[arb_idx];
                    cur_id_next  = arb_idx;
                    mask_next    = arb_onehot;
                end
            end
            COUNT: begin
                // Abort wins over natural expiry; both end in DONE.
                if (abort_hit || (cnt_reg == '0)) begin
                    state_next = DONE;
                end else begin
                    cnt_next = cnt_reg - DW'(1);
                end
            end
            DONE: begin
                state_next = IDLE;
                ptr_next   = IW'(rr_next(32'(cur_id_reg), NREQ));
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign gnt     = (state_reg == COUNT) ? mask_reg : '0;
    assign done    = (state_reg == DONE)  ? mask_reg : '0;
    assign busy    = (state_reg != IDLE);
    assign dly_en  = (state_reg == COUNT);
    assign cur_id  = cur_id_reg;
    assign dly_val = dly_val_reg;

endmodule

// File: tb/tb_apvm_delay_sched.sv
// -----------------------------------------------------------------------------
// tb_apvm_delay_sched
// Directed bench for apvm_delay_sched. A timeline model (grant edge, done edge,
// next legal arbitration edge) predicts every output each cycle; directed
// sections add hand-computed literal expectations.
// Honours APVM_DELAY_SCHED_ABORT_EN when defined.
// -----------------------------------------------------------------------------
module tb_apvm_delay_sched;

    localparam int NREQ = 4;
    localparam int DW   = 32;
    localparam int IW   = $clog2(NREQ);

`ifdef APVM_DELAY_SCHED_ABORT_EN
    localparam bit ABORT_EN = 1'b1;
`else
    localparam bit ABORT_EN = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [NREQ-1:0]     req = '0;
    logic [NREQ*DW-1:0]  delay_in = '0;
    logic [NREQ-1:0]     abort = '0;
    logic [NREQ-1:0]     gnt;
    logic [NREQ-1:0]     done;
    logic                busy;
    logic [IW-1:0]       cur_id;
    logic [DW-1:0]       dly_val;
    logic                dly_en;
    logic                aborted;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    apvm_delay_sched #(.NREQ(NREQ), .DW(DW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .delay_in (delay_in),
        .gnt      (gnt),
        .done     (done),
        .busy     (busy),
        .cur_id   (cur_id),
        .dly_val  (dly_val),
        .dly_en   (dly_en)
`ifdef APVM_DELAY_SCHED_ABORT_EN
        ,
        .abort    (abort),
        .aborted  (aborted)
`endif
    );

`ifndef APVM_DELAY_SCHED_ABORT_EN
    assign aborted = 1'b0;
`endif

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // ---------------- timeline model ----------------
    int            e = 0;          // rising edges since start
    bit            m_active = 0;
    int            k_g = 0;        // grant edge
    int            done_e = 0;     // edge after which done is shown
    int            next_arb = 0;   // earliest edge at which a grant may occur
    int            m_id = 0;
    int            m_ptr = 0;
    logic [DW-1:0] m_dly = '0;
    bit            m_ab = 0;

    function automatic int pick(input logic [NREQ-1:0] r, input int p);
        for (int o = 0; o < NREQ; o++) begin
            if (r[(p + o) % NREQ]) return (p + o) % NREQ;
        end
        return -1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active = 0; m_id = 0; m_ptr = 0; m_dly = '0; m_ab = 0; next_arb = 0;
        end else begin
            e++;
            if (m_active) begin
                if (ABORT_EN && e > k_g && e <= done_e && abort[m_id]) begin
                    done_e = e;
                    m_ab   = 1;
                end else if (e == done_e + 1) begin
                    m_active = 0;
                    m_ptr    = (m_id + 1) % NREQ;
                    next_arb = e + 1;
                end
            end else if (e >= next_arb && req != '0) begin
                m_id     = pick(req, m_ptr);
                m_dly    = delay_in[m_id*DW +: DW];
                k_g      = e;
                done_e   = e + int'(m_dly) + 1;
                m_ab     = 0;
                m_active = 1;
            end
        end
    end

    always @(negedge clk) begin
        logic [NREQ-1:0] eg, ed;
        eg = '0;
        ed = '0;
        if (m_active && e < done_e)  eg[m_id] = 1'b1;
        if (m_active && e == done_e) ed[m_id] = 1'b1;
        chk("cyc_gnt",     gnt,     eg);
        chk("cyc_done",    done,    ed);
        chk("cyc_busy",    busy,    m_active && e <= done_e);
        chk("cyc_dly_en",  dly_en,  eg != '0);
        chk("cyc_cur_id",  cur_id,  m_id);
        chk("cyc_dly_val", dly_val, m_dly);
        chk("cyc_aborted", aborted, m_active && e == done_e && m_ab);
        chk("cyc_onehot",  $countones(gnt) <= 1, 1'b1);
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_dly(input int i, input int v);
        delay_in[i*DW +: DW] = DW'(v);
    endtask

    function automatic int oh_idx(input logic [NREQ-1:0] v);
        for (int i = 0; i < NREQ; i++) if (v[i]) return i;
        return -1;
    endfunction

    int order [8];
    int dedge [8];
    int n_srv;
    int exp3 [5] = '{0, 1, 2, 3, 0};
    int gap3 [4] = '{4, 7, 5, 6};
    int exp4 [3] = '{1, 3, 1};

    initial begin
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("rst_gnt", gnt, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cur_id", cur_id, 0);
        chk("rst_dly_val", dly_val, 0);

        // single request, delay 5
        req = 4'b0001; set_dly(0, 5);
        tick();
        chk("t1_gnt_k", gnt, 4'b0001);
        chk("t1_dly_val", dly_val, 5);
        chk("t1_cur_id", cur_id, 0);
        repeat (5) tick();
        chk("t1_gnt_k5", gnt, 4'b0001);
        chk("t1_nodone_k5", done, 0);
        tick();
        chk("t1_done", done, 4'b0001);
        chk("t1_gnt_low", gnt, 0);
        chk("t1_busy_in_done", busy, 1);
        req = '0;
        tick();
        chk("t1_busy_low", busy, 0);
        chk("t1_done_once", done, 0);

        // delay 0 on requester 2
        req = 4'b0100; set_dly(2, 0);
        tick();
        chk("t2_gnt", gnt, 4'b0100);
        chk("t2_dly_val", dly_val, 0);
        tick();
        chk("t2_done", done, 4'b0100);
        req = '0;
        repeat (2) tick();
        chk("t2_idle", busy, 0);

        // reset back to ptr 0
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        // all four requesting, delays 3/1/4/2; 0 keeps requesting
        set_dly(0, 3); set_dly(1, 1); set_dly(2, 4); set_dly(3, 2);
        req = 4'b1111;
        n_srv = 0;
        for (int c = 0; c < 100 && n_srv < 5; c++) begin
            tick();
            if (done != '0) begin
                order[n_srv] = oh_idx(done);
                dedge[n_srv] = c;
                n_srv++;
                if (n_srv == 5) req = '0;
                else if (done != 4'b0001) req = req & ~done;
            end
        end
        chk("t3_count", n_srv, 5);
        for (int i = 0; i < 5; i++) chk($sformatf("t3_order%0d", i), order[i], exp3[i]);
        for (int i = 0; i < 4; i++) chk($sformatf("t3_gap%0d", i), dedge[i+1] - dedge[i], gap3[i]);
        repeat (2) tick();

        // fairness: 1 held, 3 raised during service of 1
        set_dly(1, 2); set_dly(3, 3);
        req = 4'b0010;
        tick();
        chk("t4_gnt1", gnt, 4'b0010);
        req[3] = 1'b1;
        n_srv = 0;
        for (int c = 0; c < 100 && n_srv < 3; c++) begin
            tick();
            if (done != '0) begin
                order[n_srv] = oh_idx(done);
                n_srv++;
                if (done == 4'b1000) req[3] = 1'b0;
                if (n_srv == 3) req = '0;
            end
        end
        chk("t4_count", n_srv, 3);
        for (int i = 0; i < 3; i++) chk($sformatf("t4_order%0d", i), order[i], exp4[i]);
        repeat (2) tick();

        // reset mid-count: delay 10, pulled when cnt is 4
        req = 4'b0001; set_dly(0, 10);
        tick();
        chk("t5_gnt", gnt, 4'b0001);
        repeat (6) tick();
        chk("t5_busy_pre", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("t5_gnt_rst", gnt, 0);
        chk("t5_done_rst", done, 0);
        chk("t5_busy_rst", busy, 0);
        chk("t5_dly_en_rst", dly_en, 0);
        chk("t5_cur_id_rst", cur_id, 0);
        chk("t5_dly_val_rst", dly_val, 0);
        req = '0;
        tick();
        rst_n = 1'b1;
        set_dly(1, 1); set_dly(3, 1);
        req = 4'b1010;
        tick();
        chk("t5_ptr0_gnt1", gnt, 4'b0010);
        n_srv = 0;
        for (int c = 0; c < 20 && n_srv < 1; c++) begin
            tick();
            if (done != '0) begin
                chk("t5_done1", done, 4'b0010);
                n_srv++;
                req = '0;
            end
        end
        chk("t5_count", n_srv, 1);
        repeat (2) tick();

`ifdef APVM_DELAY_SCHED_ABORT_EN
        // abort on 3rd counting edge; abort on another index ignored
        req = 4'b0100; set_dly(2, 20);
        tick();
        chk("t6_gnt", gnt, 4'b0100);
        abort = 4'b0001;
        repeat (2) tick();
        chk("t6_other_ignored", gnt, 4'b0100);
        abort = 4'b0100;
        tick();
        chk("t6_done", done, 4'b0100);
        chk("t6_aborted", aborted, 1);
        chk("t6_gnt_low", gnt, 0);
        abort = '0; req = '0;
        tick();
        chk("t6_aborted_clr", aborted, 0);
        chk("t6_idle", busy, 0);
        abort = 4'b1111;
        repeat (3) tick();
        chk("t6_idle_abort_ignored", busy, 0);
        abort = '0;
`endif

        repeat (2) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
